// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file with pending-write scoreboard.
// Contents: default address/data widths, index of the hardwired zero register,
// and fixed-width address/data typedefs for users built at the default size.
package regfile_pkg;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int ZERO_REG_IDX = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard_onehot_decoder.sv
// Parametrised binary-to-one-hot decoder.
// Ports: in[W-1:0] binary index, enable gate; out[2**W-1:0] one-hot,
// all zero when enable is low.
module onehot_decoder #(
  parameter int W = 5
) (
  input  logic [W-1:0]      in,
  input  logic              enable,
  output logic [2**W-1:0]   out
);
  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file (2 combinational read ports, 1 write port) with a
// per-register pending-write scoreboard for issue-stage hazard detection.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   issue_valid, issue_rd       mark issue_rd busy (visible next cycle)
//   rs1/rs2_addr -> _data,_busy combinational read data and pending flag
//   hazard                      rs1_busy | rs2_busy
//   wb_valid, wb_rd, wb_data    writeback; clears the busy bit
//   wb_orphan                   registered; last writeback hit a non-pending reg
// Optional build macro REGFILE_WB_BYPASS_EN: forwards same-cycle writeback data
// to the read ports and suppresses busy for the forwarded operand.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              hazard,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_orphan
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG_IDX);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             sb_q, sb_d;
  logic                         orphan_q, orphan_d;
  logic [NREGS-1:0]             wb_we_raw, iss_set_raw;
  logic [NREGS-1:0]             wb_we_onehot, iss_set, zmask;

  onehot_decoder #(.W(ADDR_W)) u_wb_dec  (.in(wb_rd),    .enable(wb_valid),    .out(wb_we_raw));
  onehot_decoder #(.W(ADDR_W)) u_iss_dec (.in(issue_rd), .enable(issue_valid), .out(iss_set_raw));

  // Masking the decodes keeps register 0 at zero and its busy bit clear.
  always_comb begin
    zmask = '1;
    if (ZERO_REG != 0) zmask[ZERO_REG_IDX] = 1'b0;
    wb_we_onehot = wb_we_raw & zmask;
    iss_set      = iss_set_raw & zmask;
  end

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ZIDX);
  endfunction

  always_comb begin
    regs_d = regs_q;
    sb_d   = sb_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wb_we_onehot[i]) regs_d[i] = wb_data;
      // A new issue supersedes a writeback from the previous producer.
      if (iss_set[i])           sb_d[i] = 1'b1;
      else if (wb_we_onehot[i]) sb_d[i] = 1'b0;
    end
    orphan_d = wb_valid && !sb_q[wb_rd] && !is_zero(wb_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q   <= '0;
      sb_q     <= '0;
      orphan_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      sb_q     <= sb_d;
      orphan_q <= orphan_d;
    end
  end

  logic fwd1, fwd2;
`ifdef REGFILE_WB_BYPASS_EN
  assign fwd1 = wb_valid && (wb_rd == rs1_addr) && !is_zero(rs1_addr);
  assign fwd2 = wb_valid && (wb_rd == rs2_addr) && !is_zero(rs2_addr);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    rs1_data = is_zero(rs1_addr) ? '0 : (fwd1 ? wb_data : regs_q[rs1_addr]);
    rs2_data = is_zero(rs2_addr) ? '0 : (fwd2 ? wb_data : regs_q[rs2_addr]);
    rs1_busy = !is_zero(rs1_addr) && !fwd1 && sb_q[rs1_addr];
    rs2_busy = !is_zero(rs2_addr) && !fwd2 && sb_q[rs2_addr];
    hazard   = rs1_busy | rs2_busy;
  end

  assign wb_orphan = orphan_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_rd, rs1_addr, rs2_addr, wb_rd;
  logic [DW-1:0] rs1_data, rs2_data, wb_data;
  logic          rs1_busy, rs2_busy, hazard, wb_valid, wb_orphan;

  regfile_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_orphan(wb_orphan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] mregs [NR];
  bit            msb   [NR];
  bit            morph;

  typedef struct { string tag; logic [DW-1:0] v; } exp_t;
  exp_t expq[$];

  function automatic bit bypass_on();
`ifdef REGFILE_WB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit fwd(input logic [AW-1:0] a);
    return bypass_on() && wb_valid && (wb_rd == a) && (a != 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (fwd(a)) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
    if (a == 0 || fwd(a)) return '0;
    return DW'(msb[a]);
  endfunction

  // Push expected outputs for the currently driven inputs, then pop/compare mid-cycle.
  task automatic settle();
    exp_t e;
    expq.push_back('{"rs1_data", exp_data(rs1_addr)});
    expq.push_back('{"rs2_data", exp_data(rs2_addr)});
    expq.push_back('{"rs1_busy", exp_busy(rs1_addr)});
    expq.push_back('{"rs2_busy", exp_busy(rs2_addr)});
    expq.push_back('{"hazard",   exp_busy(rs1_addr) | exp_busy(rs2_addr)});
    expq.push_back('{"wb_orphan", DW'(morph)});
    @(negedge clk);
    e = expq.pop_front(); chk(e.tag, rs1_data, e.v);
    e = expq.pop_front(); chk(e.tag, rs2_data, e.v);
    e = expq.pop_front(); chk(e.tag, DW'(rs1_busy), e.v);
    e = expq.pop_front(); chk(e.tag, DW'(rs2_busy), e.v);
    e = expq.pop_front(); chk(e.tag, DW'(hazard), e.v);
    e = expq.pop_front(); chk(e.tag, DW'(wb_orphan), e.v);
  endtask

  // Advance the model across the clock edge.
  task automatic tick();
    logic [DW-1:0] nregs [NR];
    bit            nsb   [NR];
    bit            norph;
    for (int i = 0; i < NR; i++) begin nregs[i] = mregs[i]; nsb[i] = msb[i]; end
    if (reset) begin
      for (int i = 0; i < NR; i++) begin nregs[i] = '0; nsb[i] = 1'b0; end
      norph = 1'b0;
    end else begin
      norph = wb_valid && !msb[wb_rd] && (wb_rd != 0);
      if (wb_valid && wb_rd != 0) begin
        nregs[wb_rd] = wb_data;
        nsb[wb_rd]   = 1'b0;
      end
      if (issue_valid && issue_rd != 0) nsb[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin mregs[i] = nregs[i]; msb[i] = nsb[i]; end
    morph = norph;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle();
    issue_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    for (int i = 0; i < NR; i++) begin mregs[i] = 'x; msb[i] = 1'b0; end
    morph = 1'b0;
    // First edge under reset establishes a known state; checks start afterwards.
    tick();
    // Inputs active during reset must be ignored.
    issue_valid = 1'b1; issue_rd = 5'd4; wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'hFFFF_0000;
    tick();
    reset = 1'b0; idle();

    for (int i = 0; i < NR; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NR-1-i);
      settle();
      chk("reset_rs1_zero", rs1_data, 32'h0);
      chk("reset_hazard", DW'(hazard), 32'h0);
      tick();
    end

    // Issue then writeback to reg 5
    issue_valid = 1'b1; issue_rd = 5'd5; step(); idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    settle(); chk("busy5", DW'(rs1_busy), 32'h1); chk("haz5", DW'(hazard), 32'h1); tick();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; step(); idle();
    settle();
    chk("data5", rs1_data, 32'hDEADBEEF); chk("busy5_clr", DW'(rs1_busy), 32'h0);
    chk("orphan5", DW'(wb_orphan), 32'h0);
    tick();

    // Simultaneous issue and writeback to pending reg 7: set wins, data written
    issue_valid = 1'b1; issue_rd = 5'd7; step();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0777; step(); idle();
    rs2_addr = 5'd7;
    settle(); chk("busy7", DW'(rs2_busy), 32'h1); chk("data7", rs2_data, 32'h777); tick();

    // Register 0 stays zero and never busy
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; step(); idle();
    settle(); chk("busy0", DW'(rs1_busy), 32'h0); tick();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; step(); idle();
    settle();
    chk("data0", rs1_data, 32'h0); chk("orphan0", DW'(wb_orphan), 32'h0);
    tick();

    // Orphan writeback to reg 9 pulses for one cycle
    rs1_addr = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; step(); idle();
    settle(); chk("orphan9", DW'(wb_orphan), 32'h1); chk("data9", rs1_data, 32'h99); tick();
    settle(); chk("orphan9_drop", DW'(wb_orphan), 32'h0); tick();

    // Reg 3: give it an old value, mark pending, then read during writeback
    issue_valid = 1'b1; issue_rd = 5'd3; step(); idle();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333; step(); idle();
    issue_valid = 1'b1; issue_rd = 5'd3; step(); idle();
    rs1_addr = 5'd3; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5A5A5A5;
    settle();
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_data3", rs1_data, 32'hA5A5A5A5); chk("byp_busy3", DW'(rs1_busy), 32'h0);
`else
    chk("nobyp_data3", rs1_data, 32'h3333); chk("nobyp_busy3", DW'(rs1_busy), 32'h1);
`endif
    tick(); idle();

    // Random traffic with occasional mid-operation reset
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = AW'($urandom_range(0, 7));
      wb_valid    = $urandom_range(0, 1);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      rs1_addr    = AW'($urandom_range(0, 7));
      rs2_addr    = AW'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
